// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns RISC-V load/store ops into word-aligned
// memory requests with byte strobes over a req/gnt/rvalid handshake, stalls
// the pipeline while an access is in flight, and returns extended load data.
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic                  nop,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           writeData,
  output logic                  stall,
  output logic [31:0]           loadData,
  output logic                  misaligned,
  output logic                  timeout,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            b_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           load_q;
  logic                  timeout_q;
  logic [CNT_W-1:0]      cnt_q;

  logic        req_any, misalign_cond, access, cnt_expired;
  logic [31:0] wdata_fmt, load_fmt, shifted;
  logic [3:0]  wstrb_fmt;

  // Decode the pipeline request and its alignment; only IDLE looks at it.
  always_comb begin
    req_any       = (memRead | memWrite) & ~nop;
    misalign_cond = ((funct3[1:0] == 2'b01) & address[0]) |
                    ((funct3 == 3'b010) & (address[1:0] != 2'b00));
    access        = req_any & ~misalign_cond;
    misaligned    = (state_q == IDLE) & req_any & misalign_cond;
    cnt_expired   = (cnt_q == CNT_LAST);
  end

  // Replicate store data across lanes and place the strobes at the byte offset.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    wdata_fmt = writeData;
    wstrb_fmt = 4'b1111;
    case (funct3)
      3'b000: begin
        wdata_fmt = {4{writeData[7:0]}};
        wstrb_fmt = 4'b0001 << address[1:0];
      end
      3'b001: begin
        wdata_fmt = {2{writeData[15:0]}};
        wstrb_fmt = 4'b0011 << address[1:0];
      end
      default: ;
    endcase
  end

  // Shift the returned word down to the addressed byte and extend it.
  always_comb begin
    shifted  = mem_rdata >> {b_q, 3'b000};
    load_fmt = mem_rdata;
    case (funct3_q)
      3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_fmt = {24'h0, shifted[7:0]};
      3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_fmt = {16'h0, shifted[15:0]};
      default: load_fmt = mem_rdata;
    endcase
  end

  // Next-state and stall: the pipeline is frozen from acceptance until DONE.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          state_d = REQ;
          stall   = 1'b1;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem_gnt) state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_rvalid || cnt_expired) state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request latching, timeout counting and load-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      b_q       <= 2'b00;
      wdata_q   <= '0;
      wstrb_q   <= 4'b0000;
      load_q    <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (access) begin
            addr_q   <= {address[ADDR_WIDTH-1:2], 2'b00};
            we_q     <= memWrite;
            funct3_q <= funct3;
            b_q      <= address[1:0];
            wdata_q  <= wdata_fmt;
            wstrb_q  <= memWrite ? wstrb_fmt : 4'b0000;
          end
        end
        REQ: begin
          if (mem_gnt && !we_q) cnt_q <= '0;
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (mem_rvalid) begin
            load_q <= load_fmt;
          end else if (cnt_expired) begin
            load_q    <= '0;
            timeout_q <= 1'b1;
          end
        end
        DONE: ;
      endcase
    end
  end

  // Memory-side outputs come straight from registered state.
  always_comb begin
    mem_req   = (state_q == REQ);
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wstrb = wstrb_q;
    timeout   = timeout_q;
    loadData  = misaligned ? 32'h0 : load_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed transactions driven cycle by cycle,
// a transaction-level model of formatting and handshake latency, and one
// compare process checking the DUT against it on every falling edge.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead, memWrite, nop;
  logic [2:0]  funct3;
  logic [31:0] address, writeData;
  logic        stall, misaligned, timeout;
  logic [31:0] loadData;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .memRead(memRead), .memWrite(memWrite), .nop(nop), .funct3(funct3),
    .address(address), .writeData(writeData),
    .stall(stall), .loadData(loadData), .misaligned(misaligned), .timeout(timeout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int stall_cnt, req_cnt;

  // Expected outputs for the current cycle, set by the driver.
  logic        chk_en = 1'b0;
  logic        e_stall, e_req, e_mis, e_to, e_we;
  logic [31:0] e_addr, e_wdata, e_load, last_load;
  logic [3:0]  e_wstrb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Store model: lane i carries data byte (i mod size); strobes cover [b, b+size).
  function automatic void st_fmt(input logic [2:0] f3, input logic [1:0] b, input logic [31:0] wd,
                                 output logic [31:0] wdata, output logic [3:0] strb);
    int size;
    size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int i = 0; i < 4; i++) begin
      wdata[8*i +: 8] = wd[8*(i % size) +: 8];
      strb[i]         = (i >= int'(b)) && (i < int'(b) + size);
    end
  endfunction

  // Load model: pick size bytes at offset b, extend by funct3[2].
  function automatic logic [31:0] ld_fmt(input logic [2:0] f3, input logic [1:0] b, input logic [31:0] rd);
    int unsigned val, mask;
    if (f3[1]) return rd;
    mask = (f3[0]) ? 32'h0000FFFF : 32'h000000FF;
    val  = (rd >> (8 * int'(b))) & mask;
    if (!f3[2] && ((val & ((mask >> 1) + 1)) != 0)) val = val | ~mask;
    return val;
  endfunction

  // Compare process: every falling edge, DUT against the expected cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", stall, e_stall);
      check("mem_req", mem_req, e_req);
      check("misaligned", misaligned, e_mis);
      check("timeout", timeout, e_to);
      check("loadData", loadData, e_load);
      if (e_req) begin
        check("mem_addr", mem_addr, e_addr);
        check("mem_we", mem_we, e_we);
        if (e_we) begin
          check("mem_wdata", mem_wdata, e_wdata);
          check("mem_wstrb", mem_wstrb, e_wstrb);
        end
      end
      if (mem_req) req_cnt++;
      if (stall) stall_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic st, input logic rq, input logic mis, input logic to);
    e_stall = st;
    e_req   = rq;
    e_mis   = mis;
    e_to    = to;
    e_load  = mis ? 32'h0 : last_load;
  endtask

  task automatic idle();
    step();
    memRead = 0; memWrite = 0; nop = 0; mem_gnt = 0; mem_rvalid = 0;
    set_exp(0, 0, 0, 0);
  endtask

  // One full access: gnt after gnt_dly cycles in REQ; rvalid rv_dly cycles
  // after gnt (0 = cycle after gnt), or never when rv_dly < 0.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
    int n;
    st_fmt(f3, addr[1:0], wd, e_wdata, e_wstrb);
    e_addr = addr & 32'hFFFF_FFFC;
    e_we   = wr;
    step();
    memRead = rd; memWrite = wr; nop = 0; funct3 = f3; address = addr; writeData = wd;
    mem_gnt = 0; mem_rvalid = 0;
    set_exp(1, 0, 0, 0);
    for (int k = 0; k <= gnt_dly; k++) begin
      step();
      mem_gnt    = (k == gnt_dly);
      mem_rvalid = (k == gnt_dly);   // response in the grant cycle must be ignored
      mem_rdata  = ~rdata;
      set_exp(1, 1, 0, 0);
    end
    if (!wr) begin
      n = (rv_dly < 0) ? TO : rv_dly + 1;
      for (int j = 0; j < n; j++) begin
        step();
        mem_gnt    = 0;
        mem_rvalid = (j == rv_dly);
        mem_rdata  = (j == rv_dly) ? rdata : ~rdata;
        set_exp(1, 0, 0, 0);
      end
    end
    step();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h5A5A_5A5A;   // stray response in DONE
    if (!wr) last_load = (rv_dly < 0) ? 32'h0 : ld_fmt(f3, addr[1:0], rdata);
    set_exp(0, 0, 0, !wr && rv_dly < 0);
  endtask

  initial begin
    logic [31:0] tw;
    logic [3:0]  ts;
    rst = 1; memRead = 0; memWrite = 0; nop = 0; funct3 = 0; address = 0; writeData = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; last_load = 0;
    e_addr = 0; e_we = 0; e_wdata = 0; e_wstrb = 0;
    set_exp(0, 0, 0, 0);

    // Pin the model against hand-computed values.
    check("model_lb",  ld_fmt(3'b000, 2'd3, 32'hA500_0000), 32'hFFFF_FFA5);
    check("model_lbu", ld_fmt(3'b100, 2'd3, 32'hA500_0000), 32'h0000_00A5);
    check("model_lh",  ld_fmt(3'b001, 2'd2, 32'h8001_7FFF), 32'hFFFF_8001);
    check("model_lhu", ld_fmt(3'b101, 2'd2, 32'h8001_7FFF), 32'h0000_8001);
    st_fmt(3'b000, 2'd3, 32'h0000_00A5, tw, ts);
    check("model_sb_wdata", tw, 32'hA5A5_A5A5);
    check("model_sb_wstrb", ts, 4'b1000);
    st_fmt(3'b001, 2'd2, 32'h0000_BEEF, tw, ts);
    check("model_sh_wstrb", ts, 4'b1100);

    // Reset state.
    @(posedge clk); @(posedge clk); #3;
    check("rst_mem_req", mem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_loadData", loadData, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_timeout", timeout, 0);
    step();
    rst = 0;
    set_exp(0, 0, 0, 0);
    chk_en = 1;
    idle();

    // SW, immediate grant: two stall cycles.
    stall_cnt = 0;
    do_access(0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, -1, 0);
    idle();
    check("sw_stall_cycles", stall_cnt, 2);

    // SB then LB/LBU at byte 3.
    do_access(0, 1, 3'b000, 32'h13, 32'h0000_00A5, 0, -1, 0);
    do_access(1, 0, 3'b000, 32'h13, 0, 0, 0, 32'hA500_0000);
    idle();
    check("lb_literal", loadData, 32'hFFFF_FFA5);
    stall_cnt = 0;
    do_access(1, 0, 3'b100, 32'h13, 0, 0, 0, 32'hA500_0000);
    idle();
    check("lbu_literal", loadData, 32'h0000_00A5);
    check("ld_stall_cycles", stall_cnt, 3);

    // LH with grant delayed 3 cycles, then LHU, SH, LW.
    req_cnt = 0;
    do_access(1, 0, 3'b001, 32'h22, 0, 3, 0, 32'h8001_7FFF);
    idle();
    check("lh_req_cycles", req_cnt, 4);
    check("lh_literal", loadData, 32'hFFFF_8001);
    do_access(1, 0, 3'b101, 32'h22, 0, 0, 2, 32'h8001_7FFF);
    idle();
    check("lhu_literal", loadData, 32'h0000_8001);
    do_access(0, 1, 3'b001, 32'h22, 32'h1234_BEEF, 1, -1, 0);
    do_access(1, 0, 3'b010, 32'h24, 0, 0, 1, 32'h1234_5678);
    idle();

    // Misaligned LW/SH and a nop-suppressed load: no request at all.
    req_cnt = 0;
    step();
    memRead = 1; funct3 = 3'b010; address = 32'h06;
    set_exp(0, 0, 1, 0);
    step();
    set_exp(0, 0, 1, 0);
    step();
    memRead = 0; memWrite = 1; funct3 = 3'b001; address = 32'h21;
    set_exp(0, 0, 1, 0);
    step();
    memWrite = 0; memRead = 1; nop = 1; funct3 = 3'b010; address = 32'h06;
    set_exp(0, 0, 0, 0);
    idle();
    check("misaligned_no_req", req_cnt, 0);

    // Timeout after TO silent WAIT cycles, stray response afterwards ignored.
    do_access(1, 0, 3'b010, 32'h30, 0, 0, -1, 32'hDEAD_0000);
    step();
    memRead = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    set_exp(0, 0, 0, 0);
    idle();
    // Response on the last permitted WAIT cycle still wins.
    do_access(1, 0, 3'b010, 32'h34, 0, 0, TO - 1, 32'h0BAD_F00D);
    idle();

    // Asynchronous reset while in WAIT.
    step();
    memRead = 1; funct3 = 3'b010; address = 32'h40; writeData = 32'h1122_3344;
    e_addr = 32'h40; e_we = 0;
    set_exp(1, 0, 0, 0);
    step();
    mem_gnt = 1;
    set_exp(1, 1, 0, 0);
    step();
    mem_gnt = 0;
    set_exp(1, 0, 0, 0);
    @(negedge clk); #2;
    chk_en = 0;
    rst = 1; memRead = 0;
    #1;
    check("arst_stall", stall, 0);
    check("arst_loadData", loadData, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_mem_wdata", mem_wdata, 0);
    check("arst_timeout", timeout, 0);
    step();
    rst = 0; last_load = 0;
    mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
    set_exp(0, 0, 0, 0);
    chk_en = 1;
    idle();
    do_access(0, 1, 3'b010, 32'h44, 32'h0102_0304, 0, -1, 0);
    idle();
    idle();
    chk_en = 0;
    check("post_rst_loadData", loadData, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage initiator between pipeline and data memory.
- Converts RISC-V load/store ops (funct3) into word-aligned requests with byte strobes over a req/gnt/rvalid handshake.
- Stalls the pipeline while an access is outstanding, then returns aligned, sign/zero-extended load data.
- Detects misalignment and response timeout.

Parameters:
- ADDR_WIDTH, 32, byte address width on both sides.
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT for mem_rvalid before abort (≥1).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- memRead  input  1  pipeline load request.
- memWrite  input  1  pipeline store request.
- nop  input  1  bubble in MEM stage; suppresses access.
- funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores).
- address  input  ADDR_WIDTH  byte address.
- writeData  input  32  store source register.
- stall  output  1  freeze pipeline (combinational).
- loadData  output  32  extended load result, valid in DONE.
- misaligned  output  1  combinational flag for misaligned access.
- timeout  output  1  one-cycle pulse in DONE after aborted read.
- mem_req  output  1  request valid (registered state).
- mem_we  output  1  1 = write.
- mem_addr  output  ADDR_WIDTH  word address, bits [1:0] = 0.
- mem_wdata  output  32  lane-replicated store data.
- mem_wstrb  output  4  byte enables, bit i = byte lane i (little-endian).
- mem_gnt  input  1  memory accepts request this cycle.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  32  read word.

Behaviour:
- access = (memRead | memWrite) & ~nop & ~misaligned. memRead & memWrite both 1: treated as write.
- Misalignment:
  - H/HU/SH with address[0] ≠ 0.
  - W/SW with address[1:0] ≠ 0.
  - misaligned = 1 in IDLE only, with no request, stall = 0, loadData = 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If access: latch address, funct3, we, formatted wdata/wstrb; go to REQ; stall = 1.
  - Else: stall = 0.
- REQ:
  - mem_req = 1; mem_addr, mem_we, mem_wdata, mem_wstrb held stable until mem_gnt.
  - On gnt: write goes to DONE; read goes to WAIT and clears the timeout counter.
  - stall = 1.
- WAIT:
  - mem_req = 0; stall = 1; counter increments each cycle.
  - On mem_rvalid: capture formatted data into loadData and go to DONE.
  - When counter reaches TIMEOUT_CYCLES without rvalid: loadData = 0, set timeout, go to DONE.
  - mem_rvalid in the same cycle as gnt is ignored; the earliest accepted response is the cycle after gnt.
- DONE:
  - stall = 0 and loadData valid, so the pipeline advances this edge.
  - timeout = 1 if the access was aborted.
  - Next state IDLE; loadData holds until the next capture.
- Pipeline inputs are held stable while stall = 1.
- Latency: write with immediate gnt stalls 2 cycles; read with gnt immediate and rvalid next cycle stalls 3 cycles.
- Store formatting, with b = address[1:0]:
  - SB: wdata = {4{writeData[7:0]}}, wstrb = 0001 << b.
  - SH: wdata = {2{writeData[15:0]}}, wstrb = 0011 << b.
  - SW: wdata = writeData, wstrb = 1111.
- Load formatting:
  - s = mem_rdata >> (8*b).
  - B = sign-extend s[7:0]; BU = zero-extend s[7:0].
  - H = sign-extend s[15:0]; HU = zero-extend s[15:0].
  - W = mem_rdata.
  - Undefined funct3 is treated as W.
- mem_rvalid outside WAIT is ignored.
- Reset (any state, mid-access allowed):
  - State = IDLE.
  - mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, loadData, timeout, counter = 0.
  - A late response after reset is dropped.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, gnt immediate -> mem_addr 0x10, wstrb 1111, wdata 0xDEADBEEF; stall high 2 cycles, low in DONE.
- SB addr 0x13 data 0x000000A5 -> mem_addr 0x10, wstrb 1000, wdata 0xA5A5A5A5; then LB 0x13 with rdata 0xA5000000 -> loadData 0xFFFFFFA5; LBU -> 0x000000A5.
- LH addr 0x22 with rdata 0x80017FFF, gnt delayed 3 cycles -> mem_req held 4 cycles with stable addr 0x20; loadData 0xFFFF8001; LHU -> 0x00008001.
- LW addr 0x06 -> misaligned = 1, mem_req never asserted, stall = 0; with nop = 1 and memRead = 1 -> no request, misaligned = 0.
- LW granted, rvalid never arrives, TIMEOUT_CYCLES = 4 -> stall released after timeout, timeout pulse 1 cycle, loadData 0; a later stray rvalid is ignored.
- rst asserted while in WAIT -> outputs zero immediately (async); next rvalid ignored; subsequent SW completes normally.
